// File: rtl/rfft_pkg.sv
// Shared widths and mux-select encodings for the 4-bank in-place radix-2 FFT datapath.
package rfft_pkg;

  localparam int RFFT_DATA_BIT   = 16;
  localparam int RFFT_ADDR_BIT   = 3;
  localparam int RFFT_MEM_HEIGHT = 8;
  localparam int RFFT_FRAC_BIT   = 14;

  // Write-data source selected by m0
  typedef enum logic {
    SRC_LOAD = 1'b0,
    SRC_BFLY = 1'b1
  } wr_src_e;

  // Input-permute settings that pass r0..r3 straight through to a0..a3
  localparam logic       M11_IDENT = 1'b0;
  localparam logic [1:0] M12_IDENT = 2'd1;
  localparam logic [1:0] M13_IDENT = 2'd1;
  localparam logic       M14_IDENT = 1'b1;

  // Output-permute settings packed as {m21, m22, m23, m24}
  localparam logic [3:0] OUT_NORMAL = 4'b0011;
  localparam logic [3:0] OUT_SWAP   = 4'b1100;

endpackage

// File: rtl/rfft_butterfly.sv
// Combinational input permute, optional Q2.14 twiddle multiply, radix-2 butterfly
// and output permute.
module rfft_butterfly
  import rfft_pkg::*;
#(
  parameter int DATA_BIT = RFFT_DATA_BIT,
  parameter int FRAC_BIT = RFFT_FRAC_BIT
) (
  input  logic [DATA_BIT-1:0] r0,
  input  logic [DATA_BIT-1:0] r1,
  input  logic [DATA_BIT-1:0] r2,
  input  logic [DATA_BIT-1:0] r3,
  input  logic                m11,
  input  logic [1:0]          m12,
  input  logic [1:0]          m13,
  input  logic                m14,
  input  logic                m21,
  input  logic                m22,
  input  logic                m23,
  input  logic                m24,
  input  logic                bypass_en,
  input  logic [DATA_BIT-1:0] w_r,
  input  logic [DATA_BIT-1:0] w_i,
  output logic [DATA_BIT-1:0] d0,
  output logic [DATA_BIT-1:0] d1,
  output logic [DATA_BIT-1:0] d2,
  output logic [DATA_BIT-1:0] d3
);

  localparam int PW = 2 * DATA_BIT;

  logic signed [DATA_BIT-1:0] a0, a1, a2, a3;
  logic signed [DATA_BIT-1:0] t_r, t_i;
  logic signed [DATA_BIT-1:0] y0, y1, y2, y3;
  logic signed [PW-1:0]       p_rr, p_ii, p_ri, p_ir;
  logic signed [PW:0]         sum_r, sum_i, sh_r, sh_i;
  logic                       unused_sh_bits;

  always_comb begin
    a0 = m11 ? r1 : r0;
    case (m12)
      2'd0:    a1 = r0;
      2'd1:    a1 = r1;
      2'd2:    a1 = r2;
      default: a1 = r3;
    endcase
    case (m13)
      2'd0:    a2 = r1;
      2'd1:    a2 = r2;
      default: a2 = r3;
    endcase
    a3 = m14 ? r3 : r2;
  end

  // Full-precision complex multiply; shifting then truncating matches floor((a*w)/2^FRAC_BIT)
  always_comb begin
    p_rr  = a2 * $signed(w_r);
    p_ii  = a3 * $signed(w_i);
    p_ri  = a2 * $signed(w_i);
    p_ir  = a3 * $signed(w_r);
    sum_r = {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
    sum_i = {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir};
    sh_r  = sum_r >>> FRAC_BIT;
    sh_i  = sum_i >>> FRAC_BIT;
    if (bypass_en) begin
      t_r = a2;
      t_i = a3;
    end else begin
      t_r = sh_r[DATA_BIT-1:0];
      t_i = sh_i[DATA_BIT-1:0];
    end
  end

  assign unused_sh_bits = ^{sh_r[PW:DATA_BIT], sh_i[PW:DATA_BIT]};

  always_comb begin
    y0 = a0 + t_r;
    y1 = a1 + t_i;
    y2 = a0 - t_r;
    y3 = a1 - t_i;
    d0 = m21 ? y2 : y0;
    d1 = m22 ? y3 : y1;
    d2 = m23 ? y2 : y0;
    d3 = m24 ? y3 : y1;
  end

endmodule

// File: rtl/rfft_4pt.sv
// Four register-file banks with combinational read and in-place write-back of
// either raw samples or butterfly results; all control comes from outside.
module rfft_4pt
  import rfft_pkg::*;
#(
  parameter int DATA_BIT   = RFFT_DATA_BIT,
  parameter int ADDR_BIT   = RFFT_ADDR_BIT,
  parameter int MEM_HEIGHT = RFFT_MEM_HEIGHT,
  parameter int FRAC_BIT   = RFFT_FRAC_BIT
) (
  input  logic [DATA_BIT-1:0]   in0,
  input  logic [DATA_BIT-1:0]   in1,
  input  logic [DATA_BIT-1:0]   in2,
  input  logic [DATA_BIT-1:0]   in3,
  output logic [DATA_BIT-1:0]   mem0_i,
  output logic [DATA_BIT-1:0]   mem1_i,
  output logic [DATA_BIT-1:0]   mem2_i,
  output logic [DATA_BIT-1:0]   mem3_i,
  output logic [DATA_BIT-1:0]   mem0,
  output logic [DATA_BIT-1:0]   mem1,
  output logic [DATA_BIT-1:0]   mem2,
  output logic [DATA_BIT-1:0]   mem3,
  input  logic                  m0,
  input  logic                  m11,
  input  logic [1:0]            m12,
  input  logic [1:0]            m13,
  input  logic                  m14,
  input  logic                  m21,
  input  logic                  m22,
  input  logic                  m23,
  input  logic                  m24,
  input  logic                  en,
  input  logic                  we,
  input  logic                  re,
  input  logic [DATA_BIT-1:0]   w_r,
  input  logic [DATA_BIT-1:0]   w_i,
  input  logic                  bypass_en,
  input  logic [4*ADDR_BIT-1:0] addr_read,
  input  logic [4*ADDR_BIT-1:0] addr_write,
  input  logic                  clk,
  input  logic                  rst
);

  logic [DATA_BIT-1:0] bank_q [4][MEM_HEIGHT];
  logic [DATA_BIT-1:0] bank_d [4][MEM_HEIGHT];
  logic [DATA_BIT-1:0] rd     [4];
  logic [DATA_BIT-1:0] wd     [4];
  logic [DATA_BIT-1:0] ld     [4];
  logic [DATA_BIT-1:0] bf     [4];
  wr_src_e             wr_src;

  // Reads see only registered contents, so a same-cycle write is not forwarded
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd[k] = '0;
      if (en && re) rd[k] = bank_q[k][addr_read[k*ADDR_BIT +: ADDR_BIT]];
    end
  end

  assign mem0 = rd[0];
  assign mem1 = rd[1];
  assign mem2 = rd[2];
  assign mem3 = rd[3];

  rfft_butterfly #(
    .DATA_BIT (DATA_BIT),
    .FRAC_BIT (FRAC_BIT)
  ) u_bfly (
    .r0        (rd[0]),
    .r1        (rd[1]),
    .r2        (rd[2]),
    .r3        (rd[3]),
    .m11       (m11),
    .m12       (m12),
    .m13       (m13),
    .m14       (m14),
    .m21       (m21),
    .m22       (m22),
    .m23       (m23),
    .m24       (m24),
    .bypass_en (bypass_en),
    .w_r       (w_r),
    .w_i       (w_i),
    .d0        (bf[0]),
    .d1        (bf[1]),
    .d2        (bf[2]),
    .d3        (bf[3])
  );

  assign ld[0]  = in0;
  assign ld[1]  = in1;
  assign ld[2]  = in2;
  assign ld[3]  = in3;
  assign wr_src = wr_src_e'(m0);

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      wd[k] = (wr_src == SRC_BFLY) ? bf[k] : ld[k];
    end
  end

  assign mem0_i = wd[0];
  assign mem1_i = wd[1];
  assign mem2_i = wd[2];
  assign mem3_i = wd[3];

  always_comb begin
    bank_d = bank_q;
    if (en && we) begin
      for (int k = 0; k < 4; k++) begin
        bank_d[k][addr_write[k*ADDR_BIT +: ADDR_BIT]] = wd[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        for (int i = 0; i < MEM_HEIGHT; i++) begin
          bank_q[k][i] <= '0;
        end
      end
    end else begin
      bank_q <= bank_d;
    end
  end

endmodule

// File: tb/tb_rfft_4pt.sv
// Directed bench for rfft_4pt: reset, load, butterfly/permute/twiddle vectors,
// wrap-around, enables and in-place write-back, all with hand-computed results.
module tb_rfft_4pt;

  logic [15:0] in0, in1, in2, in3;
  logic [15:0] mem0_i, mem1_i, mem2_i, mem3_i;
  logic [15:0] mem0, mem1, mem2, mem3;
  logic        m0, m11, m14, m21, m22, m23, m24;
  logic [1:0]  m12, m13;
  logic        en, we, re, bypass_en;
  logic [15:0] w_r, w_i;
  logic [11:0] addr_read, addr_write;
  logic        clk, rst;

  int vectors;
  int miscompares;

  rfft_4pt dut (
    .in0        (in0),
    .in1        (in1),
    .in2        (in2),
    .in3        (in3),
    .mem0_i     (mem0_i),
    .mem1_i     (mem1_i),
    .mem2_i     (mem2_i),
    .mem3_i     (mem3_i),
    .mem0       (mem0),
    .mem1       (mem1),
    .mem2       (mem2),
    .mem3       (mem3),
    .m0         (m0),
    .m11        (m11),
    .m12        (m12),
    .m13        (m13),
    .m14        (m14),
    .m21        (m21),
    .m22        (m22),
    .m23        (m23),
    .m24        (m24),
    .en         (en),
    .we         (we),
    .re         (re),
    .w_r        (w_r),
    .w_i        (w_i),
    .bypass_en  (bypass_en),
    .addr_read  (addr_read),
    .addr_write (addr_write),
    .clk        (clk),
    .rst        (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Datapath configuration: {m11,m12,m13,m14} input permute, {m21..m24} output permute
  task automatic applyStimulus(input logic src, input logic [5:0] in_sel,
                               input logic [3:0] out_sel, input logic byp,
                               input logic [15:0] wr, input logic [15:0] wi);
    m0                     = src;
    {m11, m12, m13, m14}   = in_sel;
    {m21, m22, m23, m24}   = out_sel;
    bypass_en              = byp;
    w_r                    = wr;
    w_i                    = wi;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic checkRead(input string tag, input int e0, input int e1, input int e2, input int e3);
    checkOutput({tag, ".mem0"}, mem0, 16'(e0));
    checkOutput({tag, ".mem1"}, mem1, 16'(e1));
    checkOutput({tag, ".mem2"}, mem2, 16'(e2));
    checkOutput({tag, ".mem3"}, mem3, 16'(e3));
  endtask

  task automatic checkWrite(input string tag, input int e0, input int e1, input int e2, input int e3);
    checkOutput({tag, ".mem0_i"}, mem0_i, 16'(e0));
    checkOutput({tag, ".mem1_i"}, mem1_i, 16'(e1));
    checkOutput({tag, ".mem2_i"}, mem2_i, 16'(e2));
    checkOutput({tag, ".mem3_i"}, mem3_i, 16'(e3));
  endtask

  function automatic logic [11:0] addr4(input int b0, input int b1, input int b2, input int b3);
    return {3'(b3), 3'(b2), 3'(b1), 3'(b0)};
  endfunction

  localparam logic [5:0] IDENT = {1'b0, 2'd1, 2'd1, 1'b1};
  localparam logic [5:0] PERM  = {1'b1, 2'd0, 2'd2, 1'b0};

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b0; en = 1'b0; we = 1'b0; re = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    addr_read = '0; addr_write = '0;
    applyStimulus(1'b0, IDENT, 4'b0011, 1'b1, 16'd0, 16'd0);
    tick();

    $display("[TB] fill banks with nonzero data, then reset with we held high");
    en = 1'b1; we = 1'b1;
    for (int k = 0; k < 8; k++) begin
      addr_write = addr4(k, k, k, k);
      in0 = 16'(100 + k); in1 = 16'(200 + k); in2 = 16'(300 + k); in3 = 16'(400 + k);
      tick();
    end
    rst = 1'b1;
    addr_write = addr4(2, 2, 2, 2);
    tick();
    rst = 1'b0; we = 1'b0; re = 1'b1;
    for (int k = 0; k < 8; k++) begin
      addr_read = addr4(k, k, k, k);
      #1;
      checkRead($sformatf("reset.a%0d", k), 0, 0, 0, 0);
    end

    $display("[TB] load k, k+8, k+16, k+24 at address k");
    we = 1'b1;
    applyStimulus(1'b0, IDENT, 4'b0011, 1'b1, 16'd0, 16'd0);
    for (int k = 0; k < 8; k++) begin
      addr_write = addr4(k, k, k, k);
      in0 = 16'(k); in1 = 16'(k + 8); in2 = 16'(k + 16); in3 = 16'(k + 24);
      #1;
      checkWrite($sformatf("load.a%0d", k), k, k + 8, k + 16, k + 24);
      tick();
    end
    we = 1'b0;
    addr_read = addr4(3, 3, 3, 3);
    #1;
    checkRead("load.rd3", 3, 11, 19, 27);
    addr_read = addr4(1, 2, 3, 4);
    #1;
    checkRead("rd.packing", 1, 10, 19, 28);

    $display("[TB] butterfly vectors on address 3");
    addr_read = addr4(3, 3, 3, 3);
    applyStimulus(1'b1, IDENT, 4'b0011, 1'b1, 16'd0, 16'd0);
    checkWrite("bypass", 22, 38, -16, -16);
    applyStimulus(1'b1, PERM, 4'b1100, 1'b1, 16'd0, 16'd0);
    checkWrite("permute", -16, -16, 38, 22);
    applyStimulus(1'b1, IDENT, 4'b0011, 1'b0, 16'd16384, 16'd0);
    checkWrite("tw.one", 22, 38, -16, -16);
    applyStimulus(1'b1, IDENT, 4'b0011, 1'b0, 16'd0, 16'd16384);
    checkWrite("tw.j", -24, 30, 30, -8);
    // T = (floor(-92680/16384), floor(532910/16384)) = (-6, 32)
    applyStimulus(1'b1, IDENT, 4'b0011, 1'b0, 16'd11585, 16'd11585);
    checkWrite("tw.rot45", -3, 43, 9, -21);

    $display("[TB] wrap-around at address 7");
    we = 1'b1;
    applyStimulus(1'b0, IDENT, 4'b0011, 1'b1, 16'd0, 16'd0);
    addr_write = addr4(7, 7, 7, 7);
    in0 = 16'h7FFF; in1 = 16'h8000; in2 = 16'd1; in3 = 16'd1;
    tick();
    we = 1'b0;
    addr_read = addr4(7, 7, 7, 7);
    applyStimulus(1'b1, IDENT, 4'b0011, 1'b1, 16'd0, 16'd0);
    checkWrite("wrap", -32768, -32767, 32766, 32767);

    $display("[TB] enables");
    addr_read  = addr4(3, 3, 3, 3);
    addr_write = addr4(3, 3, 3, 3);
    en = 1'b0; we = 1'b1;
    tick();
    en = 1'b1; we = 1'b0;
    #1;
    checkRead("en0.hold", 3, 11, 19, 27);
    tick();
    checkRead("we0.hold", 3, 11, 19, 27);
    re = 1'b0;
    #1;
    checkRead("re0.rd", 0, 0, 0, 0);
    checkWrite("re0.bfly", 0, 0, 0, 0);

    $display("[TB] in-place write-back");
    re = 1'b1; we = 1'b1;
    #1;
    checkRead("inplace.old", 3, 11, 19, 27);
    tick();
    we = 1'b0;
    #1;
    checkRead("inplace.new", 22, 38, -16, -16);
    addr_read = addr4(2, 2, 2, 2);
    #1;
    checkRead("inplace.neighbour", 2, 10, 18, 26);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rfft_4pt.md
Name: rfft_4pt

Overview:
- In-place radix-2 FFT datapath with four memory banks.
- Each cycle: read one word per bank, permute the four words, apply one complex radix-2 butterfly with optional twiddle, permute the results, write back in place.
- An external sequencer drives all addresses, mux selects and twiddles; this block holds no control state.
- Also loads raw samples from in0..in3 into the banks.

Parameters:
- DATA_BIT, 16, sample/twiddle width, signed two's complement
- ADDR_BIT, 3, per-bank address width
- MEM_HEIGHT, 8, words per bank (= 2**ADDR_BIT)
- FRAC_BIT, 14, twiddle fraction bits (Q2.14; 1.0 = 16384)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in0..in3  in  DATA_BIT each  load data for banks 0..3
- mem0_i..mem3_i  out  DATA_BIT each  write data presented to banks 0..3
- mem0..mem3  out  DATA_BIT each  read data of banks 0..3
- m0  in  1  write source: 0=in0..3, 1=butterfly results
- m11  in  1  input-permute select for a0
- m12  in  2  input-permute select for a1
- m13  in  2  input-permute select for a2
- m14  in  1  input-permute select for a3
- m21..m24  in  1 each  output-permute selects
- en  in  1  global memory enable
- we  in  1  write enable
- re  in  1  read enable
- w_r, w_i  in  DATA_BIT each  twiddle real/imag
- bypass_en  in  1  1 = skip twiddle multiply
- addr_read  in  4*ADDR_BIT  bank k address = bits [k*ADDR_BIT +: ADDR_BIT]
- addr_write  in  4*ADDR_BIT  same packing as addr_read
- Positional order is the list above minus rst, starting at in0 and ending with clk; rst is appended after clk.

Behaviour:
- Storage: four arrays of MEM_HEIGHT x DATA_BIT registers.
- Read: combinational. memk = (en & re) ? bankk[addr_read_k] : 0.
- Write: at posedge clk, if en & we, bankk[addr_write_k] <= memk_i.
- Same-address read/write in one cycle returns the old value; the new value is visible the following cycle.
- Reset: rst=1 at posedge clears every word of every bank to 0. Reset overrides we. Reset mid-operation simply clears the banks. Outputs are combinational, so after reset they read 0.
- Input permute (r = mem0..mem3):
  - a0 = m11 ? r1 : r0
  - a1 = r[m12]; m12 of 0/1/2/3 selects r0/r1/r2/r3
  - a2: m13 of 0/1/2/3 selects r1/r2/r3/r3
  - a3 = m14 ? r3 : r2
  - Identity is m11=0, m12=1, m13=1, m14=1.
- Twiddle:
  - X = a0 + j*a1, Y = a2 + j*a3.
  - If bypass_en: T = Y.
  - Else T_r = (a2*w_r - a3*w_i) >>> FRAC_BIT and T_i = (a2*w_i + a3*w_r) >>> FRAC_BIT.
  - Products are full 2*DATA_BIT signed; sums use 2*DATA_BIT+1 bits; arithmetic shift; the result is truncated to DATA_BIT.
- Butterfly: y0 = a0+T_r, y1 = a1+T_i, y2 = a0-T_r, y3 = a1-T_i, all DATA_BIT wrap-around (no saturation, no scaling).
- Output permute:
  - d0 = m21 ? y2 : y0
  - d1 = m22 ? y3 : y1
  - d2 = m23 ? y2 : y0
  - d3 = m24 ? y3 : y1
  - Normal is (0,0,1,1); swap is (1,1,0,0).
- Write data: memk_i = m0 ? dk : ink.
- Latency: the whole path is combinational, so one read-compute-write per clock and the result is stored at the next edge.
- With re=0 the butterfly sees zeros.

Decomposition:
- Shared package rfft_pkg holds DATA_BIT, ADDR_BIT, MEM_HEIGHT, FRAC_BIT and the mux-select encodings (identity/swap constants).
- One natural sub-module: rfft_butterfly, containing the input permute, twiddle multiply, butterfly and output permute, all purely combinational. The top level holds the four banks and the m0 mux.

Test Plan:
- Reset: fill banks with nonzero data, rst=1 for 1 cycle, en=re=1, any address -> mem0..3 = 0 at all 8 addresses.
- Load: m0=0, en=we=1, for k=0..7 drive all addr_write fields = k and in0..3 = k, k+8, k+16, k+24 -> reading address 3 gives mem0..3 = 3,11,19,27. While loading, memk_i equals ink.
- Bypass butterfly: r=(3,11,19,27), identity permute, bypass_en=1, m21..24=0,0,1,1, m0=1 -> mem0_i..3_i = 22, 38, -16, -16. Written in place, they are visible next cycle.
- Permutes: same r, m11=1, m12=0, m13=2, m14=0, m21..24=1,1,0,0 -> mem0_i..3_i = -16, -16, 38, 22.
- Twiddle: bypass_en=0.
  - w_r=16384, w_i=0 -> same as bypass: 22, 38, -16, -16.
  - w_r=0, w_i=16384 -> T=(-27,19) -> mem0_i..3_i = -24, 30, 30, -8.
- Enables: en=0 or we=0 for a cycle -> contents unchanged. With re=0 -> mem0..3 = 0 and, with m0=1 and bypass, mem0_i..3_i = 0.
